// File: rtl/cond_unit_pkg.sv
// Shared constants for the condition/flag stage: ARM condition codes and
// NZCV bit positions within the flag register.
package cond_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_unit_cond_check.sv
// Purely combinational ARM condition evaluator: (cond, flags) -> condex.
module cond_check
  import cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // NOTE: every path assigns condex (default arm included), so no latch is inferred.
  always_comb begin
    case (cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = (n == v);
      COND_LT: condex = (n != v);
      COND_GT: condex = ~z & (n == v);
      COND_LE: condex = z | (n != v);
      default: condex = 1'b1;  // AL and the unconditional space
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Condition/flag stage after the ALU: NZCV register, condition capture and
// write-enable gating. Define COND_FAILCNT_EN to add the FailCount counter.
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             CondEval,
  input  logic             PCS,
  input  logic             NextPC,
  input  logic             RegW,
  input  logic             MemW,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic             CondExR
`ifdef COND_FAILCNT_EN
  ,
  output logic [CNT_W-1:0] FailCount
`endif
);

  logic condex_c;
  logic eval;
  logic ce;

  cond_check u_cond_check (
    .cond   (Cond),
    .flags  (Flags),
    .condex (condex_c)
  );

  // The strobe is ignored while reset is held so gated writes stay low.
  assign eval = CondEval & reset;
  assign ce   = eval ? condex_c : CondExR;

  assign PCWrite  = (PCS & ce) | NextPC;
  assign RegWrite = RegW & ce;
  assign MemWrite = MemW & ce;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values (condex_c sees the old Flags on a same-cycle write).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Flags   <= 4'b0000;
      CondExR <= 1'b0;
    end else begin
      if (CondEval) CondExR <= condex_c;
      if (FlagW[1] & ce) Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (FlagW[0] & ce) Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

`ifdef COND_FAILCNT_EN
  logic [CNT_W-1:0] fail_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fail_cnt <= '0;
    end else if (CondEval && !condex_c && (fail_cnt != '1)) begin
      fail_cnt <= fail_cnt + 1'b1;
    end
  end

  assign FailCount = fail_cnt;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = |CNT_W;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: stimulus pushes expected outputs, a monitor
// pops and compares them at the falling edge (or on an explicit async sample).
module tb_cond_unit;
  import cond_unit_pkg::*;

  typedef struct packed {
    logic [3:0]  flags;
    logic        cexr;
    logic        pcw;
    logic        regw;
    logic        memw;
    logic [15:0] fc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  Cond;
  logic [3:0]  ALUFlags;
  logic [1:0]  FlagW;
  logic        CondEval, PCS, NextPC, RegW, MemW;
  logic        PCWrite, RegWrite, MemWrite;
  logic [3:0]  Flags;
  logic        CondExR;
  logic [15:0] FailCount;

  int checks = 0;
  int errors = 0;

  exp_t  exp_q[$];
  string name_q[$];
  event  sample_now;

  logic [3:0]  flags_m;
  logic        cexr_m;
  logic [15:0] fc_m;

  cond_unit dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .CondEval (CondEval),
    .PCS      (PCS),
    .NextPC   (NextPC),
    .RegW     (RegW),
    .MemW     (MemW),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags),
    .CondExR  (CondExR)
`ifdef COND_FAILCNT_EN
    ,
    .FailCount(FailCount)
`endif
  );

`ifndef COND_FAILCNT_EN
  assign FailCount = 16'h0000;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: drain every pending expectation whenever outputs are sampled.
  initial begin
    exp_t e, a;
    string n;
    forever begin
      @(negedge clk or sample_now);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a.flags = Flags;
        a.cexr  = CondExR;
        a.pcw   = PCWrite;
        a.regw  = RegWrite;
        a.memw  = MemWrite;
`ifdef COND_FAILCNT_EN
        a.fc    = FailCount;
`else
        a.fc    = e.fc;
`endif
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got flags=%b cexr=%b pcw=%b regw=%b memw=%b fc=%0d, want flags=%b cexr=%b pcw=%b regw=%b memw=%b fc=%0d",
                   n, a.flags, a.cexr, a.pcw, a.regw, a.memw, a.fc,
                   e.flags, e.cexr, e.pcw, e.regw, e.memw, e.fc);
        end
      end
    end
  end

  task automatic push(input string name, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic drive(input logic [3:0] cond, input logic [3:0] alu,
                       input logic [1:0] fw, input logic ev, input logic pcs,
                       input logic npc, input logic rw, input logic mw);
    Cond = cond; ALUFlags = alu; FlagW = fw; CondEval = ev;
    PCS = pcs; NextPC = npc; RegW = rw; MemW = mw;
  endtask

  // One instruction cycle; exp_cx is the hand-computed condition result for
  // cond against the flags the bench expects to be in the register.
  task automatic step(input string name, input logic [3:0] cond,
                      input logic [3:0] alu, input logic [1:0] fw,
                      input logic ev, input logic pcs, input logic npc,
                      input logic rw, input logic mw, input logic exp_cx);
    logic ce;
    exp_t e;
    @(posedge clk);
    #1;
    drive(cond, alu, fw, ev, pcs, npc, rw, mw);
    ce = (ev && reset) ? exp_cx : cexr_m;
    e.flags = flags_m;
    e.cexr  = cexr_m;
    e.pcw   = (pcs & ce) | npc;
    e.regw  = rw & ce;
    e.memw  = mw & ce;
    e.fc    = fc_m;
    push(name, e);
    if (reset) begin
      if (fw[1] && ce) flags_m[3:2] = alu[3:2];
      if (fw[0] && ce) flags_m[1:0] = alu[1:0];
      if (ev) cexr_m = exp_cx;
      if (ev && !exp_cx && fc_m != 16'hFFFF) fc_m = fc_m + 16'd1;
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    drive(4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0]  sweep_flags [3];
    logic [15:0] sweep_mask  [3];
    exp_t e;
    sweep_flags = '{4'b0011, 4'b1000, 4'b0100};
    sweep_mask  = '{16'hE966, 16'hEA9A, 16'hE6A9};

    reset = 1'b0;
    drive(4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    flags_m = 4'b0000; cexr_m = 1'b0; fc_m = 16'h0000;

    // Strobe and flag write are ignored while reset is held.
    step("in_reset", COND_AL, 4'b1111, 2'b11, 1, 1, 0, 1, 1, 1'b1);
    release_reset();

    step("rst_idle",  COND_EQ, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 1'b0);
    step("nextpc",    COND_EQ, 4'b0000, 2'b00, 0, 0, 1, 1, 0, 1'b0);
    step("al_flagw",  COND_AL, 4'b0100, 2'b11, 1, 0, 0, 1, 0, 1'b1);
    step("flags_new", COND_EQ, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 1'b0);
    step("eq_eval",   COND_EQ, 4'b0000, 2'b00, 1, 0, 0, 1, 0, 1'b1);
    step("eq_hold",   COND_EQ, 4'b0000, 2'b00, 0, 0, 0, 1, 0, 1'b0);
    step("ne_fail",   COND_NE, 4'b0000, 2'b00, 1, 1, 0, 1, 1, 1'b0);
    step("ne_after",  COND_NE, 4'b0000, 2'b00, 0, 1, 0, 1, 1, 1'b0);
    step("set_1111",  COND_AL, 4'b1111, 2'b11, 1, 0, 0, 0, 0, 1'b1);
    step("partial",   COND_AL, 4'b0000, 2'b10, 1, 0, 0, 0, 0, 1'b1);
    step("ge_fail",   COND_GE, 4'b0000, 2'b00, 1, 0, 0, 1, 0, 1'b0);
    step("ge_after",  COND_GE, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 1'b0);

    // Full condition sweep against three flag patterns.
    for (int s = 0; s < 3; s++) begin
      step($sformatf("set_%b", sweep_flags[s]), COND_AL, sweep_flags[s],
           2'b11, 1, 0, 0, 0, 0, 1'b1);
      for (int c = 0; c < 16; c++) begin
        step($sformatf("sweep_%b_c%0d", sweep_flags[s], c), 4'(c), 4'b0000,
             2'b00, 1, 1, 0, 1, 1, sweep_mask[s][c]);
      end
    end

    // Same-cycle hazard: EQ sees old Z=0, so the flag write is suppressed.
    step("clr_flags", COND_AL, 4'b0000, 2'b11, 1, 0, 0, 0, 0, 1'b1);
    step("hazard",    COND_EQ, 4'b0100, 2'b11, 1, 0, 0, 1, 0, 1'b0);
    step("hazard_after", COND_EQ, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 1'b0);

    // Asynchronous reset between the evaluation and the write cycle.
    step("pre_al", COND_AL, 4'b0000, 2'b00, 1, 0, 0, 1, 0, 1'b1);
    @(posedge clk);
    #1;
    drive(COND_AL, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    e = '{flags: flags_m, cexr: 1'b1, pcw: 1'b0, regw: 1'b1, memw: 1'b0, fc: fc_m};
    push("pre_async", e);
    ->sample_now;
    #1;
    reset = 1'b0;
    #1;
    flags_m = 4'b0000; cexr_m = 1'b0; fc_m = 16'h0000;
    e = '{flags: 4'b0000, cexr: 1'b0, pcw: 1'b0, regw: 1'b0, memw: 1'b0, fc: 16'h0000};
    push("async_rst", e);
    ->sample_now;
    step("rst_ev_ignored", COND_AL, 4'b1111, 2'b11, 1, 1, 0, 1, 1, 1'b1);
    release_reset();
    step("fresh_ne", COND_NE, 4'b0000, 2'b00, 1, 0, 0, 1, 0, 1'b1);
    step("fresh_hold", COND_NE, 4'b0000, 2'b00, 0, 0, 0, 1, 0, 1'b0);

`ifdef COND_FAILCNT_EN
    // Preload the counter to all-ones; a further failure must not wrap it.
    @(posedge clk);
    #1;
    force dut.fail_cnt = 16'hFFFF;
    #1;
    release dut.fail_cnt;
    fc_m = 16'hFFFF;
    step("sat_fail",  COND_EQ, 4'b0000, 2'b00, 1, 0, 0, 1, 0, 1'b0);
    step("sat_hold",  COND_EQ, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 1'b0);
`endif

    step("final_idle", COND_EQ, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 1'b0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
